// File: rtl/patp_pkg.sv
// patp_pkg: shared opcode, state and ALU encodings for the PATP control path
package patp_pkg;
   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_JMP   = 3'b100;
   localparam logic [2:0] OP_JZ    = 3'b101;
   localparam logic [2:0] OP_NOP   = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;
   typedef enum logic [1:0] {
      ST_FETCH  = 2'b00,
      ST_DECODE = 2'b01,
      ST_EXEC   = 2'b10,
      ST_HALT   = 2'b11
   } state_t;
   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;
endpackage

// File: rtl/patp_ctrl_decode.sv
// patp_ctrl_decode: combinational opcode classifier for the PATP sequencer
// Ports: opcode (in) -> is_mem_rd, is_mem_wr, is_jump, is_cond, alu_op, is_halt (out)
// PATP_CTRL_HALT_EN: when undefined, opcode 111 is never flagged as halt (runs as NOP)
module patp_ctrl_decode
   import patp_pkg::*;
(
   input  logic [2:0] opcode,
   output logic       is_mem_rd,
   output logic       is_mem_wr,
   output logic       is_jump,
   output logic       is_cond,
   output logic [1:0] alu_op,
   output logic       is_halt
);
   assign is_mem_rd = opcode == OP_LOAD || opcode == OP_ADD || opcode == OP_SUB;
   assign is_mem_wr = opcode == OP_STORE;
   assign is_jump   = opcode == OP_JMP || opcode == OP_JZ;
   assign is_cond   = opcode == OP_JZ;
   assign alu_op    = opcode == OP_ADD ? ALU_ADD : opcode == OP_SUB ? ALU_SUB : ALU_PASS;
`ifdef PATP_CTRL_HALT_EN
   assign is_halt   = opcode == OP_HALT;
`else
   assign is_halt   = 1'b0;
`endif
endmodule

// File: rtl/patp_ctrl.sv
// patp_ctrl: fetch/decode/execute sequencer driving PATP memory, PC, IR and accumulator strobes
// Ports: clk, rst (async, active-high), opcode, acc_zero, mem_ready (in);
//        mem_rd, mem_wr, addr_sel, ir_we, pc_inc, pc_load, acc_we, alu_op, halted, state (out)
// PATP_CTRL_HALT_EN: enables opcode 111 to stop the core; otherwise 111 is a NOP and halted is 0
module patp_ctrl
   import patp_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       acc_zero,
   input  logic       mem_ready,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       addr_sel,
   output logic       ir_we,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       acc_we,
   output logic [1:0] alu_op,
   output logic       halted,
   output logic [1:0] state
);
   state_t st, nxt;
   logic run, is_mem_rd, is_mem_wr, is_jump, is_cond, is_halt, is_mem;
   logic [1:0] dec_alu;
   patp_ctrl_decode u_dec (
      .opcode    (opcode),
      .is_mem_rd (is_mem_rd),
      .is_mem_wr (is_mem_wr),
      .is_jump   (is_jump),
      .is_cond   (is_cond),
      .alu_op    (dec_alu),
      .is_halt   (is_halt)
   );
   // every strobe is gated by rst so an access in flight drops the moment reset rises
   assign run    = !rst;
   assign is_mem = is_mem_rd || is_mem_wr;
   assign state  = st;
`ifdef PATP_CTRL_HALT_EN
   assign halted = run && st == ST_HALT;
`else
   assign halted = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) st <= ST_FETCH;
      else     st <= nxt;
   always_comb begin
      nxt      = st;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      acc_we   = 1'b0;
      alu_op   = ALU_PASS;
      unique case (st)
         ST_FETCH: begin
            mem_rd = run;
            ir_we  = run && mem_ready;
            pc_inc = run && mem_ready;
            nxt    = mem_ready ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: nxt = ST_EXEC;
         ST_EXEC: begin
            addr_sel = run && is_mem;
            mem_rd   = run && is_mem_rd;
            mem_wr   = run && is_mem_wr;
            acc_we   = run && is_mem_rd && mem_ready;
            alu_op   = run && is_mem_rd ? dec_alu : ALU_PASS;
            pc_load  = run && is_jump && (!is_cond || acc_zero);
            nxt      = is_halt ? ST_HALT : (is_mem && !mem_ready) ? ST_EXEC : ST_FETCH;
         end
         ST_HALT: nxt = ST_HALT;
      endcase
   end
endmodule

// File: tb/tb_patp_ctrl.sv
// tb_patp_ctrl: table-driven, randomized and corner-case checks of patp_ctrl
module tb_patp_ctrl;
   logic clk = 1'b0, rst = 1'b1, acc_zero = 1'b0, mem_ready = 1'b1;
   logic [2:0] opcode = 3'd0;
   logic mem_rd, mem_wr, addr_sel, ir_we, pc_inc, pc_load, acc_we, halted;
   logic [1:0] alu_op, state;
   typedef struct {
      logic [2:0]  op;
      logic        rdy;
      logic        az;
      logic [11:0] exp;
   } vec_t;
   vec_t tv[$];
   int n_cmp = 0, n_bad = 0;
   logic [11:0] got, e_fw, e_fr, e_dc, e_x0, e_xj, e_xs, e_h;
   patp_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .acc_zero  (acc_zero),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .addr_sel  (addr_sel),
      .ir_we     (ir_we),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .acc_we    (acc_we),
      .alu_op    (alu_op),
      .halted    (halted),
      .state     (state)
   );
   always #5 clk = ~clk;
   assign got = {state, halted, alu_op, acc_we, pc_load, pc_inc, ir_we, addr_sel, mem_wr, mem_rd};
   function automatic logic [11:0] mk(input logic [1:0] st, input logic h, input logic [1:0] alu,
         input logic aw, input logic pl, input logic pi, input logic iw, input logic as,
         input logic mw, input logic mr);
      return {st, h, alu, aw, pl, pi, iw, as, mw, mr};
   endfunction
   function automatic logic [11:0] e_rd(input logic [1:0] alu, input logic aw);
      return mk(2'd2, 1'b0, alu, aw, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
   endfunction
   task automatic add(input logic [2:0] op, input logic rdy, input logic az, input logic [11:0] exp);
      vec_t v;
      v.op = op;
      v.rdy = rdy;
      v.az = az;
      v.exp = exp;
      tv.push_back(v);
   endtask
   task automatic chk(input string nm, input logic [11:0] g, input logic [11:0] e);
      n_cmp++;
      if (g !== e) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", nm, g, e);
      end
   endtask
   task automatic apply(input vec_t v, input string nm);
      opcode = v.op;
      mem_ready = v.rdy;
      acc_zero = v.az;
      #1 chk(nm, got, v.exp);
      @(negedge clk);
   endtask
   // one instruction as a list of cycles: fw fetch waits, decode, exec with ew waits for memory ops
   task automatic model(input logic [2:0] op, input int fw, input int ew, input logic az);
      logic [1:0] alu;
      alu = op == 3'd2 ? 2'd1 : op == 3'd3 ? 2'd2 : 2'd0;
      for (int i = 0; i < fw; i++) add(3'($urandom), 1'b0, 1'($urandom), e_fw);
      add(3'($urandom), 1'b1, 1'($urandom), e_fr);
      add(op, 1'($urandom), 1'($urandom), e_dc);
      if (op <= 3'd3) begin
         for (int i = 0; i < ew; i++) add(op, 1'b0, 1'($urandom), op == 3'd1 ? e_xs : e_rd(alu, 1'b0));
         add(op, 1'b1, 1'($urandom), op == 3'd1 ? e_xs : e_rd(alu, 1'b1));
      end else
         add(op, 1'($urandom), az, (op == 3'd4 || (op == 3'd5 && az)) ? e_xj : e_x0);
   endtask
   initial begin
      e_fw = mk(2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
      e_fr = mk(2'd0, 0, 2'd0, 0, 0, 1, 1, 0, 0, 1);
      e_dc = mk(2'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
      e_x0 = mk(2'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
      e_xj = mk(2'd2, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0);
      e_xs = mk(2'd2, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0);
      e_h  = mk(2'd3, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
      // reset with mem_ready high: everything quiet
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         opcode = 3'($urandom);
         #1 chk("reset", got, 12'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      add(3'd2, 1, 0, e_fr); add(3'd2, 1, 0, e_dc); add(3'd2, 1, 0, e_rd(2'd1, 1'b1));
      add(3'd1, 0, 0, e_fw); add(3'd1, 1, 0, e_fr); add(3'd1, 0, 0, e_dc);
      add(3'd1, 0, 0, e_xs); add(3'd1, 0, 0, e_xs); add(3'd1, 1, 0, e_xs);
      add(3'd5, 1, 1, e_fr); add(3'd5, 1, 1, e_dc); add(3'd5, 1, 1, e_xj);
      add(3'd5, 1, 0, e_fr); add(3'd5, 1, 0, e_dc); add(3'd5, 1, 0, e_x0);
      add(3'd4, 1, 0, e_fr); add(3'd4, 0, 0, e_dc); add(3'd4, 0, 0, e_xj);
      add(3'd3, 1, 0, e_fr); add(3'd3, 1, 0, e_dc); add(3'd3, 0, 0, e_rd(2'd2, 1'b0));
      add(3'd3, 1, 0, e_rd(2'd2, 1'b1));
      add(3'd0, 1, 0, e_fr); add(3'd0, 1, 0, e_dc); add(3'd0, 1, 1, e_rd(2'd0, 1'b1));
      add(3'd6, 1, 0, e_fr); add(3'd6, 1, 0, e_dc); add(3'd6, 1, 0, e_x0);
      foreach (tv[i]) apply(tv[i], $sformatf("vec%0d", i));
      tv.delete();
      for (int k = 0; k < 150; k++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
`ifdef PATP_CTRL_HALT_EN
         if (op == 3'd7) op = 3'd6;
`endif
         model(op, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
      end
      foreach (tv[i]) apply(tv[i], $sformatf("rand%0d", i));
      tv.delete();
      // reset while a fetch is waiting on memory
      opcode = 3'd0;
      mem_ready = 1'b0;
      #1 chk("mid_fetch_wait", got, e_fw);
      #2 rst = 1'b1;
      #1 chk("rst_drop", got, 12'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      #1 chk("rst_hold", got, 12'd0);
      @(negedge clk);
      rst = 1'b0;
      add(3'd0, 0, 0, e_fw); add(3'd0, 1, 0, e_fr); add(3'd0, 1, 0, e_dc);
      add(3'd0, 1, 0, e_rd(2'd0, 1'b1));
      // opcode 111
      add(3'd7, 1, 0, e_fr); add(3'd7, 1, 0, e_dc); add(3'd7, 1, 0, e_x0);
`ifdef PATP_CTRL_HALT_EN
      for (int i = 0; i < 20; i++) add(3'd7, 1'(i), 1'($urandom), e_h);
`else
      add(3'd7, 0, 0, e_fw); add(3'd7, 1, 0, e_fr);
`endif
      foreach (tv[i]) apply(tv[i], $sformatf("seq%0d", i));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/patp_ctrl.md
# patp_ctrl

Control sequencer for the PATP core: the consumer of the instruction register's 3-bit opcode and 5-bit operand. It runs the fetch/decode/execute cycle and drives the memory, program-counter, IR and accumulator strobes. Memory accesses use a ready handshake, so wait states are supported. It sits between the IR, PC, ALU/accumulator and the memory port.

## Interface
- No parameters. Instruction width is fixed at 8 bits, split as opcode[7:5] and operand[4:0].
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-high
- opcode  in  3  current IR opcode
- acc_zero  in  1  accumulator equals zero
- mem_ready  in  1  memory completes the requested read/write this cycle
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request (data is the accumulator)
- addr_sel  out  1  address source: 0 = PC, 1 = IR operand
- ir_we  out  1  IR load strobe (fetched byte)
- pc_inc  out  1  PC increment strobe
- pc_load  out  1  PC load-from-operand strobe
- acc_we  out  1  accumulator write strobe
- alu_op  out  2  00 pass memory data, 01 add, 10 subtract; 11 is never driven
- halted  out  1  core stopped
- state  out  2  current state, for debug

## Operation
- Opcodes (decided):
  - 000 LOAD, 001 STORE, 010 ADD, 011 SUB
  - 100 JMP, 101 JZ, 110 NOP, 111 HALT
- States: FETCH=00, DECODE=01, EXEC=10, HALT=11.
- FETCH:
  - Drive addr_sel=0 and mem_rd=1, and hold them until mem_ready.
  - In the mem_ready cycle, also assert ir_we=1 and pc_inc=1, then go to DECODE.
- DECODE: one cycle with no strobes; the IR is now valid. Go to EXEC.
- EXEC:
  - LOAD/ADD/SUB: addr_sel=1, mem_rd=1. In the mem_ready cycle assert acc_we=1 with alu_op 00/01/10 respectively, then go to FETCH.
  - STORE: addr_sel=1, mem_wr=1. Go to FETCH in the mem_ready cycle.
  - JMP: pc_load=1 for one cycle, then FETCH.
  - JZ: pc_load=acc_zero for one cycle, then FETCH.
  - NOP: no strobes for one cycle, then FETCH.
  - HALT: go to HALT.
- HALT: all strobes 0 and halted=1. The block stays here until rst; mem_ready is ignored.
- Outputs are combinational from state, opcode and mem_ready. Each strobe lasts exactly one cycle except mem_rd/mem_wr, which are held until ready.
- mem_rd and mem_wr are never both 1.
- opcode is sampled only in EXEC. The IR does not change outside FETCH.

## Timing
- While rst is high: state=FETCH and every output is 0, including mem_rd.
- The first mem_rd=1 appears in the first cycle after rst deasserts.
- With zero wait states (mem_ready tied 1):
  - LOAD/ADD/SUB/STORE: 3 cycles per instruction.
  - JMP/JZ/NOP: 3 cycles per instruction.
  - HALT: 3 cycles to reach HALT.
- Each cycle of mem_ready=0 adds one cycle in FETCH or EXEC.
- mem_ready asserted while no request is outstanding (DECODE, HALT, jump/NOP EXEC) is ignored.
- rst mid-access: the request drops immediately (asynchronously). No ir_we/acc_we/pc strobe may fire.
- JZ with acc_zero changing mid-cycle: the value in the EXEC cycle decides.

## Configuration
- PATP_CTRL_HALT_EN
  - Defined: opcode 111 enters HALT as described above.
  - Undefined: 111 executes as NOP, the HALT state is unreachable, and halted is tied 0.

## Structure
- Shared package patp_pkg holds:
  - opcode constants (OP_LOAD..OP_HALT)
  - state encoding constants (ST_FETCH..ST_HALT)
  - ALU_PASS/ALU_ADD/ALU_SUB
- Sub-module patp_ctrl_decode is natural: purely combinational opcode → {is_mem_rd, is_mem_wr, is_jump, is_cond, alu_op, is_halt}. The FSM stays in patp_ctrl.

## Test plan
- Reset with mem_ready=1 → all outputs 0 during rst; cycle after release: state=00, mem_rd=1, addr_sel=0.
- opcode=010 (ADD), mem_ready=1 → FETCH (ir_we, pc_inc), DECODE, EXEC (mem_rd, addr_sel=1, acc_we, alu_op=01); back in FETCH on cycle 4.
- STORE with mem_ready low for 2 EXEC cycles → mem_wr held 3 cycles; acc_we never 1; FETCH follows the ready cycle.
- JZ with acc_zero=1 then again with acc_zero=0 → pc_load=1 for one EXEC cycle in the first case, 0 in the second; no mem_rd/mem_wr in EXEC.
- opcode=111 with PATP_CTRL_HALT_EN defined → halted=1 and state=11 in the cycle after EXEC, held for 20 cycles with mem_ready toggling. Macro undefined → NOP timing, halted stays 0.
- rst asserted mid-FETCH while waiting on mem_ready → mem_rd drops within the same cycle, ir_we never pulses, and fetch restarts after release.
